// File: rtl/bp_clint_ctrl.sv
// bp_clint_ctrl: single-hart CLINT (msip, mtimecmp, mtime) behind a one-at-a-time
// load/store port at device base 0x02xx_xxxx.
//
// Build option: define BP_CLINT_PRESCALER_EN to advance mtime from an internal
// prescaler every prescale_p clocks (tick_i is then ignored). When undefined, mtime
// advances on every cycle tick_i is high and no prescaler logic exists.
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_READY | idle, ready_o=1; an accepted request moves to S_RESP
//   S_RESP  | response held on v_o/data_o/err_o until yumi_i
module bp_clint_ctrl #(
  parameter int prescale_p = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        v_i,
  output logic        ready_o,
  input  logic        w_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] data_i,
  output logic        v_o,
  input  logic        yumi_i,
  output logic [63:0] data_o,
  output logic        err_o,
  input  logic        tick_i,
  output logic        soft_irq_o,
  output logic        timer_irq_o
);

  localparam logic [31:0] addr_msip_lp    = 32'h0200_0000;
  localparam logic [31:0] addr_cmp_lo_lp  = 32'h0200_4000;
  localparam logic [31:0] addr_cmp_hi_lp  = 32'h0200_4004;
  localparam logic [31:0] addr_time_lo_lp = 32'h0200_BFF8;
  localparam logic [31:0] addr_time_hi_lp = 32'h0200_BFFC;

  // A zero prescale would never advance mtime; refuse to elaborate.
  if (prescale_p < 1) begin : g_bad_prescale
    $error("bp_clint_ctrl: prescale_p must be >= 1");
  end

  typedef enum logic {
    S_READY = 1'b0,
    S_RESP  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        timer_irq_q, timer_irq_d;

  logic        accept;
  logic        tick_w;
  logic        is_8b;
  logic        size_ok;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp_lo;
  logic        hit_cmp_hi;
  logic        hit_time_lo;
  logic        hit_time_hi;
  logic        mapped;
  logic        dec_err;
  logic        wr_ok;
  logic        wr_msip;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_time_lo;
  logic        wr_time_hi;
  logic [31:0] wr_lo_data;
  logic [31:0] wr_hi_data;
  logic [63:0] rd_data;

`ifdef BP_CLINT_PRESCALER_EN
  localparam int presc_w_lp = (prescale_p > 1) ? $clog2(prescale_p) : 1;
  localparam logic [presc_w_lp-1:0] presc_max_lp = presc_w_lp'(prescale_p - 1);

  logic [presc_w_lp-1:0] presc_q, presc_d;

  // Prescaler wraps every prescale_p clocks; the wrap cycle is the mtime tick.
  always_comb begin
    presc_d = (presc_q == presc_max_lp) ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) presc_q <= '0;
    else            presc_q <= presc_d;
  end

  assign tick_w = (presc_q == presc_max_lp);
`else
  assign tick_w = tick_i;
`endif

  assign accept = v_i & (state_q == S_READY);

  // Address/size decode and legality of the presented request.
  always_comb begin
    is_8b       = (size_i == 2'b11);
    size_ok     = size_i[1];
    aligned     = is_8b ? (addr_i[2:0] == 3'b000) : (addr_i[1:0] == 2'b00);
    hit_msip    = (addr_i == addr_msip_lp);
    hit_cmp_lo  = (addr_i == addr_cmp_lo_lp);
    hit_cmp_hi  = (addr_i == addr_cmp_hi_lp);
    hit_time_lo = (addr_i == addr_time_lo_lp);
    hit_time_hi = (addr_i == addr_time_hi_lp);
    mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;
    // msip is a 4 B register only; an 8 B access there is rejected.
    dec_err     = ~size_ok | ~aligned | ~mapped | (hit_msip & is_8b);
  end

  // Store enables per register half; an 8 B store to a low address covers both halves.
  always_comb begin
    wr_ok      = accept & w_i & ~dec_err;
    wr_msip    = wr_ok & hit_msip;
    wr_cmp_lo  = wr_ok & hit_cmp_lo;
    wr_cmp_hi  = wr_ok & ((hit_cmp_lo & is_8b) | hit_cmp_hi);
    wr_time_lo = wr_ok & hit_time_lo;
    wr_time_hi = wr_ok & ((hit_time_lo & is_8b) | hit_time_hi);
    wr_lo_data = data_i[31:0];
    wr_hi_data = is_8b ? data_i[63:32] : data_i[31:0];
  end

  // Load mux on current register values, i.e. before any same-cycle increment.
  always_comb begin
    rd_data = '0;
    if (hit_msip) begin
      rd_data = {63'd0, msip_q};
    end else if (hit_cmp_lo) begin
      rd_data = is_8b ? mtimecmp_q : {32'd0, mtimecmp_q[31:0]};
    end else if (hit_cmp_hi) begin
      rd_data = {32'd0, mtimecmp_q[63:32]};
    end else if (hit_time_lo) begin
      rd_data = is_8b ? mtime_q : {32'd0, mtime_q[31:0]};
    end else if (hit_time_hi) begin
      rd_data = {32'd0, mtime_q[63:32]};
    end
  end

  // Request/response handshake FSM and response capture.
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_READY: begin
        ready_o = 1'b1;
        if (v_i) begin
          state_d     = S_RESP;
          resp_err_d  = dec_err;
          resp_data_d = (!w_i && !dec_err) ? rd_data : 64'd0;
        end
      end
      S_RESP: begin
        v_o = 1'b1;
        if (yumi_i) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // Architectural register updates; a store to mtime overrides a same-cycle tick.
  always_comb begin
    msip_d     = wr_msip ? wr_lo_data[0] : msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) mtimecmp_d[31:0]  = wr_lo_data;
    if (wr_cmp_hi) mtimecmp_d[63:32] = wr_hi_data;
    mtime_d = mtime_q;
    if (wr_time_lo | wr_time_hi) begin
      if (wr_time_lo) mtime_d[31:0]  = wr_lo_data;
      if (wr_time_hi) mtime_d[63:32] = wr_hi_data;
    end else if (tick_w) begin
      mtime_d = mtime_q + 64'd1;
    end
    timer_irq_d = (mtime_q >= mtimecmp_q);
  end

  // State and register file with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_READY;
      msip_q      <= 1'b0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q     <= 64'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign data_o      = resp_data_q;
  assign err_o       = resp_err_q;
  assign soft_irq_o  = msip_q;
  assign timer_irq_o = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_ctrl.sv
// Bench for bp_clint_ctrl (default build: mtime advanced by tick_i).
module tb_bp_clint_ctrl;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic        w_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic [63:0] data_i;
  logic        v_o;
  logic        yumi_i;
  logic [63:0] data_o;
  logic        err_o;
  logic        tick_i;
  logic        soft_irq_o;
  logic        timer_irq_o;

  always #5 clk = ~clk;

  bp_clint_ctrl #(.prescale_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .addr_i(addr_i), .size_i(size_i), .data_i(data_i), .v_o(v_o), .yumi_i(yumi_i),
    .data_o(data_o), .err_o(err_o), .tick_i(tick_i), .soft_irq_o(soft_irq_o),
    .timer_irq_o(timer_irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: word-addressed register map ----------------
  bit        chk_en = 1'b0;
  bit        m_busy, m_msip, m_irq, m_rerr;
  bit [63:0] m_cmp, m_time, m_rdata;
  bit        mdl_nirq, mdl_twr, mdl_err;
  int        mdl_id;

  // 0 msip, 1 cmp lo, 2 cmp hi, 3 time lo, 4 time hi, -1 unmapped
  function automatic int word_id(input bit [31:0] a);
    case (a)
      32'h0200_0000: return 0;
      32'h0200_4000: return 1;
      32'h0200_4004: return 2;
      32'h0200_BFF8: return 3;
      32'h0200_BFFC: return 4;
      default:       return -1;
    endcase
  endfunction

  // 4 B: any mapped word. 8 B: must start on a 64-bit register (cmp or time).
  function automatic bit acc_err(input bit [31:0] a, input bit [1:0] sz);
    if (sz == 2'b10) return word_id(a) < 0;
    if (sz == 2'b11) return (a[2:0] != 3'b000) || !(word_id(a) == 1 || word_id(a) == 3);
    return 1'b1;
  endfunction

  function automatic bit [31:0] read_word(input int id);
    case (id)
      0:       return {31'd0, m_msip};
      1:       return m_cmp[31:0];
      2:       return m_cmp[63:32];
      3:       return m_time[31:0];
      4:       return m_time[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic write_word(input int id, input bit [31:0] d);
    case (id)
      0:       m_msip = d[0];
      1:       m_cmp[31:0]   = d;
      2:       m_cmp[63:32]  = d;
      3:       m_time[31:0]  = d;
      4:       m_time[63:32] = d;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (!reset_n_i) begin
      m_busy = 0; m_msip = 0; m_irq = 0; m_rerr = 0;
      m_cmp = '1; m_time = 0; m_rdata = 0;
    end else begin
      mdl_nirq = (m_time >= m_cmp);
      mdl_twr  = 0;
      if (m_busy) begin
        if (yumi_i) m_busy = 0;
      end else if (v_i) begin
        m_busy  = 1;
        mdl_err = acc_err(addr_i, size_i);
        mdl_id  = word_id(addr_i);
        m_rerr  = mdl_err;
        m_rdata = 0;
        if (!mdl_err && !w_i)
          m_rdata = (size_i == 2'b11) ? {read_word(mdl_id + 1), read_word(mdl_id)}
                                      : {32'd0, read_word(mdl_id)};
        if (!mdl_err && w_i) begin
          write_word(mdl_id, data_i[31:0]);
          if (size_i == 2'b11) write_word(mdl_id + 1, data_i[63:32]);
          if (mdl_id >= 3) mdl_twr = 1;
        end
      end
      if (tick_i && !mdl_twr) m_time = m_time + 64'd1;
      m_irq = mdl_nirq;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("ready_o", ready_o, !m_busy);
      check1("v_o", v_o, m_busy);
      if (m_busy) begin
        check64("data_o", data_o, m_rdata);
        check1("err_o", err_o, m_rerr);
      end
      check1("soft_irq_o", soft_irq_o, m_msip);
      check1("timer_irq_o", timer_irq_o, m_irq);
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] rd;
  logic        re;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Issue one request from READY, wait (bounded) for the response, consume it
  // on the first response cycle. Returns at posedge+1 with the DUT back in READY.
  task automatic req(input bit w, input logic [31:0] a, input logic [1:0] sz,
                     input logic [63:0] d, input bit tk,
                     output logic [63:0] rdata, output logic rerr);
    int n;
    v_i = 1; w_i = w; addr_i = a; size_i = sz; data_i = d; tick_i = tk;
    step();
    v_i = 0; w_i = 0; tick_i = 0; data_i = 0;
    n = 0;
    while (!v_o && n < 8) begin step(); n++; end
    check1("resp_arrives", v_o, 1'b1);
    rdata = data_o; rerr = err_o;
    yumi_i = 1;
    step();
    yumi_i = 0;
  endtask

  task automatic tick(input int k);
    tick_i = 1;
    repeat (k) @(posedge clk);
    #1 tick_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 0; v_i = 0; w_i = 0; addr_i = 0; size_i = 0; data_i = 0;
    yumi_i = 0; tick_i = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    check1("rst_ready", ready_o, 1'b1);
    check1("rst_v", v_o, 1'b0);
    check64("rst_data", data_o, 64'd0);
    check1("rst_err", err_o, 1'b0);
    check1("rst_timer", timer_irq_o, 1'b0);
    check1("rst_soft", soft_irq_o, 1'b0);
    reset_n_i = 1;
    step();

    // mtime after reset
    req(0, 32'h0200_BFF8, 2'b11, 0, 0, rd, re);
    check64("mtime_rst", rd, 64'd0);
    check1("mtime_rst_err", re, 1'b0);

    // timer interrupt raise via tick, then drop via mtimecmp store
    req(1, 32'h0200_4000, 2'b11, 64'h10, 0, rd, re);
    req(1, 32'h0200_BFF8, 2'b11, 64'h0F, 0, rd, re);
    check1("irq_before_tick", timer_irq_o, 1'b0);
    tick(1);
    check1("irq_same_edge", timer_irq_o, 1'b0);
    step();
    check1("irq_next_edge", timer_irq_o, 1'b1);
    req(1, 32'h0200_4000, 2'b11, 64'h20, 0, rd, re);
    check1("irq_dropped", timer_irq_o, 1'b0);

    // software interrupt
    req(1, 32'h0200_0000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, re);
    check1("soft_set", soft_irq_o, 1'b1);
    req(0, 32'h0200_0000, 2'b10, 0, 0, rd, re);
    check64("msip_read", rd, 64'h1);
    req(1, 32'h0200_0000, 2'b10, 64'h0, 0, rd, re);
    check1("soft_clr", soft_irq_o, 1'b0);

    // wrap and store-wins-over-tick
    req(1, 32'h0200_BFF8, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, re);
    tick(1);
    req(0, 32'h0200_BFF8, 2'b11, 0, 0, rd, re);
    check64("mtime_wrap", rd, 64'd0);
    req(1, 32'h0200_BFF8, 2'b11, 64'h1234_5678_9ABC_DEF0, 1, rd, re);
    req(0, 32'h0200_BFF8, 2'b11, 0, 1, rd, re);
    check64("store_wins", rd, 64'h1234_5678_9ABC_DEF0);
    req(0, 32'h0200_BFF8, 2'b11, 0, 0, rd, re);
    check64("load_then_tick", rd, 64'h1234_5678_9ABC_DEF1);
    tick(3);
    req(0, 32'h0200_BFF8, 2'b10, 0, 0, rd, re);
    check64("mtime_lo32", rd, 64'h0000_0000_9ABC_DEF4);
    req(0, 32'h0200_BFFC, 2'b10, 0, 0, rd, re);
    check64("mtime_hi32", rd, 64'h0000_0000_1234_5678);

    // half store to mtimecmp
    req(1, 32'h0200_4004, 2'b10, 64'h1111_1111_AAAA_5555, 0, rd, re);
    req(0, 32'h0200_4000, 2'b11, 0, 0, rd, re);
    check64("cmp_half", rd, 64'hAAAA_5555_0000_0020);

    // error cases
    req(0, 32'h0200_4004, 2'b11, 0, 0, rd, re);
    check1("err_misalign8", re, 1'b1);
    check64("err_misalign8_d", rd, 64'd0);
    req(0, 32'h0200_1000, 2'b10, 0, 0, rd, re);
    check1("err_unmapped", re, 1'b1);
    check64("err_unmapped_d", rd, 64'd0);
    req(0, 32'h0200_BFF8, 2'b01, 0, 0, rd, re);
    check1("err_size", re, 1'b1);
    req(0, 32'h0200_4002, 2'b10, 0, 0, rd, re);
    check1("err_misalign4", re, 1'b1);
    req(1, 32'h0200_0000, 2'b11, 64'h1, 0, rd, re);
    check1("err_msip8", re, 1'b1);
    check1("err_msip8_nochg", soft_irq_o, 1'b0);
    req(1, 32'h0200_BFF8, 2'b01, 64'h55, 0, rd, re);
    check1("err_store_size", re, 1'b1);
    req(0, 32'h0200_BFF8, 2'b11, 0, 0, rd, re);
    check64("err_nochg", rd, 64'h1234_5678_9ABC_DEF4);

    // hold response for 5 cycles, then reset while in RESP
    v_i = 1; w_i = 0; addr_i = 32'h0200_4000; size_i = 2'b10;
    step();
    v_i = 0;
    for (int i = 0; i < 5; i++) begin
      check64("hold_data", data_o, 64'h0000_0000_0000_0020);
      check1("hold_ready", ready_o, 1'b0);
      check1("hold_v", v_o, 1'b1);
      step();
    end
    reset_n_i = 0;
    step();
    reset_n_i = 1;
    check1("rst_resp_v", v_o, 1'b0);
    check1("rst_resp_ready", ready_o, 1'b1);
    step();
    check1("post_rst_v", v_o, 1'b0);
    req(0, 32'h0200_BFF8, 2'b11, 0, 0, rd, re);
    check64("post_rst_mtime", rd, 64'd0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_clint_ctrl.md
# bp_clint_ctrl

Single-hart core-local interruptor (CLINT) controller. It owns the machine software-interrupt pending bit (msip), the 64-bit mtimecmp register and the free-running 64-bit mtime counter. It services one memory-mapped load/store at a time from the uncached I/O path, at device base 0x02xx_xxxx. It drives the software and timer interrupt lines into the core's interrupt logic.

## Interface
Parameters:
- `prescale_p`, default 8: clock cycles per mtime increment when the internal prescaler is compiled in (must be ≥1).

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i`  in  1  core clock.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `v_i`  in  1  request valid.
- `ready_o`  out  1  request accepted when `v_i & ready_o`.
- `w_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  32  physical address, low 32 bits.
- `size_i`  in  2  2'b10 = 4 B, 2'b11 = 8 B; other encodings are errors.
- `data_i`  in  64  store data; 4 B stores use `data_i[31:0]`.
- `v_o`  out  1  response valid.
- `yumi_i`  in  1  response consumed; legal only while `v_o`.
- `data_o`  out  64  load data; 4 B loads are zero-extended in `[31:0]`.
- `err_o`  out  1  response is an error; qualified by `v_o`.
- `tick_i`  in  1  one-cycle RTC pulse; used only without the prescaler.
- `soft_irq_o`  out  1  msip bit.
- `timer_irq_o`  out  1  registered `mtime >= mtimecmp` (unsigned).

## Operation
- Register map:
  - msip at 0x0200_0000, 4 B; bit 0 is significant, other bits read 0 and writes to them are ignored.
  - mtimecmp at 0x0200_4000, 8 B; the upper half is 0x0200_4004 for 4 B accesses.
  - mtime at 0x0200_BFF8, 8 B; the upper half is 0x0200_BFFC for 4 B accesses.
- 8 B accesses must be 8 B aligned.
- Error cases, each producing a response with `err_o=1`:
  - unmapped address;
  - misaligned access;
  - illegal size;
  - 8 B access to msip.
- On an error: no state changes, and `data_o=0`.
- FSM has two states:
  - `READY`: `ready_o=1`. Acceptance moves to `RESP`.
  - `RESP`: `ready_o=0`, `v_o=1`. `yumi_i` returns to `READY`.
- Exactly one request is outstanding at a time.
- Load data is captured from the register values on the accept cycle, before any same-cycle mtime increment. `data_o`/`err_o` are held stable throughout `RESP`.
- Stores update the target register on the accept edge. A 4 B store changes only the addressed half.
- mtime increments by 1 per tick and wraps from 2^64−1 to 0.
- If a store to mtime and a tick occur in the same cycle, the store wins and the increment is dropped.
- Reset values: msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtime=0.
- Output reset values: `timer_irq_o=0`, `soft_irq_o=0`, `v_o=0`, `ready_o=1` (first cycle after reset), `data_o=0`, `err_o=0`.
- Prescaler counter resets to 0.
- Reset asserted in `RESP` discards the pending response; there is no `v_o` after reset.

## Timing
- Request accepted at edge N; `v_o` is high from cycle N+1. Response latency is 1 cycle.
- `yumi_i` on the same cycle `v_o` rises gives back-to-back throughput of one request per 2 cycles.
- `soft_irq_o` follows msip with zero added latency: it changes at the store edge.
- `timer_irq_o` at cycle t+1 = (mtime ≥ mtimecmp) evaluated on the register values at cycle t.
  - A store making the compare true at edge N raises the IRQ at edge N+1.
  - Likewise, a tick making it true at edge N raises it at N+1.
- Writing mtimecmp larger than mtime deasserts `timer_irq_o` one edge after the store.
- `tick_i` is sampled every cycle; a pulse held for k cycles gives k increments.

## Configuration
- `BP_CLINT_PRESCALER_EN`
  - Defined: an internal counter counts 0..`prescale_p`−1 and increments mtime on the cycle it wraps, i.e. every `prescale_p` cycles; the first increment is `prescale_p` cycles after reset. `tick_i` is ignored.
  - Undefined: mtime increments on each cycle `tick_i=1`, and no prescaler logic is present.

## Test plan
- After reset, mtime read (8 B, 0x0200_BFF8) → `v_o` on the next cycle with `data_o=0`, `err_o=0`; `timer_irq_o=0`.
- Store 8 B 0x10 to mtimecmp, store 0x0F to mtime, then one tick → `timer_irq_o` rises exactly 1 cycle after the mtime change to 0x10. A subsequent store of 0x20 to mtimecmp drops it 1 cycle after.
- 4 B store 0x1 to 0x0200_0000 → `soft_irq_o=1` immediately after the edge. 4 B load returns 0x1. Storing 0x0 clears it.
- Store 0xFFFF_FFFF_FFFF_FFFF to mtime, then one tick → mtime reads 0. Store to mtime on a tick cycle → the read-back equals the stored value exactly.
- 8 B load at 0x0200_4004, a 4 B load at 0x0200_1000, and size 2'b01 → each returns `err_o=1`, `data_o=0`, with no register change.
- Hold `yumi_i=0` for 5 cycles in `RESP` → `data_o` stable and `ready_o=0`. Assert `reset_n_i=0` in `RESP` → `v_o=0`, `ready_o=1` after release.
